mux_scan_reg: RTL and testbench

- Parametrised, registered successor to the dual 4-input data selector: CHANNELS independent N-input multiplexers sharing one select.
- Adds a registered output stage, an internal scan counter that auto-steps the select each clock, a counter load, and a terminal-count flag.
- Used as a time-multiplexed bus/front-panel sampler in the machine datapath.
- Defaults (CHANNELS=2, INPUTS=4, WIDTH=1) reproduce the dual 4:1 part in direct mode, plus one clock of latency.

---
 rtl/mux_scan_pkg.sv | 17 +
 rtl/mux_scan_ctr.sv | 41 ++++
 rtl/mux_scan_reg.sv | 103 ++++++++++
 tb/tb_mux_scan_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the scanning multiplexer register.
// Latency: n/a (package only).
// Backpressure: n/a.
package mux_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of a select able to address every one of n inputs (at least 1 bit).
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Modulo-INPUTS scan counter with synchronous load and advance enable.
// Latency: count changes on the edge after load/adv is sampled.
// Backpressure: none; load overrides advance, out-of-range load values clamp to 0.
module mux_scan_ctr
  import mux_scan_pkg::*;
#(
  parameter  int INPUTS = 4,
  localparam int SELW   = sel_width(INPUTS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            adv,
  input  logic [SELW-1:0] load_val,
  output logic [SELW-1:0] cnt
);

  localparam logic [SELW-1:0] LAST_SEL = SELW'(INPUTS - 1);

  logic [SELW-1:0] cnt_q;
  logic [SELW-1:0] cnt_d;

  // Next count: load beats advance; the counter never leaves 0..INPUTS-1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val > LAST_SEL) ? '0 : load_val;
    end else if (adv) begin
      cnt_d = (cnt_q == LAST_SEL) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mux_scan_reg.sv
// CHANNELS independent INPUTS:1 muxes on a shared direct or auto-scanned select, registered.
// Latency: 1 clock from I/S/E_N/MODE to Y; no combinational input-to-output path.
// Backpressure: none; outputs update every clock.
module mux_scan_reg
  import mux_scan_pkg::*;
#(
  parameter  int CHANNELS = 2,
  parameter  int INPUTS   = 4,
  parameter  int WIDTH    = 1,
  localparam int SELW     = sel_width(INPUTS)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CHANNELS*INPUTS*WIDTH-1:0] I,
  input  logic [CHANNELS-1:0]          E_N,
  input  logic [SELW-1:0]              S,
  input  logic                         MODE,
  input  logic                         SCAN_EN,
  input  logic                         LOAD,
  output logic [CHANNELS*WIDTH-1:0]    Y,
  output logic [SELW-1:0]              SEL_Q,
  output logic                         TC,
  output logic                         VALID
);

  localparam logic [SELW-1:0] LAST_SEL = SELW'(INPUTS - 1);

  logic [SELW-1:0]           cnt;
  logic [SELW-1:0]           sel_eff;
  logic                      sel_ok;
  logic                      scan_adv;

  logic [CHANNELS*WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]           sel_q, sel_d;
  logic                      tc_q, tc_d;
  logic                      valid_q, valid_d;

  // Counter only advances in scan mode; load acts in any mode.
  assign scan_adv = (MODE == MODE_SCAN) && SCAN_EN;

  mux_scan_ctr #(
    .INPUTS (INPUTS)
  ) u_ctr (
    .clk      (CLK),
    .rst      (RST),
    .load     (LOAD),
    .adv      (scan_adv),
    .load_val (S),
    .cnt      (cnt)
  );

  // Select seen by the muxes: the pre-update count in scan mode, else S.
  always_comb begin
    sel_eff = (MODE == MODE_SCAN) ? cnt : S;
    sel_ok  = (sel_eff <= LAST_SEL);
  end

  // Per-channel mux; disabled channels and out-of-range selects give 0.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] ch_in [INPUTS];
    logic [WIDTH-1:0] ch_y;

    for (genvar k = 0; k < INPUTS; k++) begin : g_in
      assign ch_in[k] = I[(c*INPUTS + k)*WIDTH +: WIDTH];
    end

    // Select one input of this channel, gated by enable and range.
    always_comb begin
      ch_y = '0;
      if (!E_N[c] && sel_ok) ch_y = ch_in[sel_eff];
    end

    assign y_d[c*WIDTH +: WIDTH] = ch_y;
  end

  // Next values for the remaining output flops.
  always_comb begin
    sel_d   = sel_eff;
    tc_d    = (MODE == MODE_SCAN) && (sel_eff == LAST_SEL);
    valid_d = ~&E_N;
  end

  // Output stage with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q     <= '0;
      sel_q   <= '0;
      tc_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      tc_q    <= tc_d;
      valid_q <= valid_d;
    end
  end

  assign Y     = y_q;
  assign SEL_Q = sel_q;
  assign TC    = tc_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg at CHANNELS=3, INPUTS=5, WIDTH=8 (non power-of-two select range).
// Directed scenarios followed by random stimulus, all against a behavioural model.
// Outputs sampled 1 time unit after the rising edge.
module tb_mux_scan_reg;

  localparam int CH = 3;
  localparam int IN = 5;
  localparam int W  = 8;
  localparam int SW = 3;

  logic              CLK = 1'b0;
  logic              RST;
  logic [CH*IN*W-1:0] I;
  logic [CH-1:0]     E_N;
  logic [SW-1:0]     S;
  logic              MODE;
  logic              SCAN_EN;
  logic              LOAD;
  logic [CH*W-1:0]   Y;
  logic [SW-1:0]     SEL_Q;
  logic              TC;
  logic              VALID;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the scan counter as a plain integer 0..IN-1.
  int m_cnt = 0;

  mux_scan_reg #(
    .CHANNELS (CH),
    .INPUTS   (IN),
    .WIDTH    (W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .I       (I),
    .E_N     (E_N),
    .S       (S),
    .MODE    (MODE),
    .SCAN_EN (SCAN_EN),
    .LOAD    (LOAD),
    .Y       (Y),
    .SEL_Q   (SEL_Q),
    .TC      (TC),
    .VALID   (VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_data();
    for (int b = 0; b < CH*IN; b++) I[b*W +: W] = W'($urandom);
  endtask

  // One clock: predict from the inputs and model state, clock, compare, update model.
  task automatic step();
    logic [CH*W-1:0] ey;
    int  sel;
    int  esel;
    logic etc, evld;
    ey   = '0;
    sel  = MODE ? m_cnt : int'(S);
    esel = sel;
    etc  = MODE && (sel == IN - 1);
    evld = (E_N != '1);
    for (int c = 0; c < CH; c++)
      if (!E_N[c] && sel < IN) ey[c*W +: W] = I[(c*IN + sel)*W +: W];
    if (RST) begin
      ey = '0; esel = 0; etc = 1'b0; evld = 1'b0;
    end
    @(posedge CLK);
    #1;
    chk("Y", 64'(Y), 64'(ey));
    chk("SEL_Q", 64'(SEL_Q), 64'(esel));
    chk("TC", 64'(TC), 64'(etc));
    chk("VALID", 64'(VALID), 64'(evld));
    if (RST)                 m_cnt = 0;
    else if (LOAD)           m_cnt = (int'(S) < IN) ? int'(S) : 0;
    else if (MODE && SCAN_EN) m_cnt = (m_cnt + 1) % IN;
  endtask

  initial begin
    RST = 1'b1; I = '0; E_N = '1; S = '0; MODE = 1'b0; SCAN_EN = 1'b0; LOAD = 1'b0;
    rand_data();
    MODE = 1'b1; SCAN_EN = 1'b1; E_N = '0;
    step();
    chk("rst_y", 64'(Y), 64'd0);
    chk("rst_vld", 64'(VALID), 64'd0);
    RST = 1'b0;

    // Direct mode, enable patterns.
    MODE = 1'b0; SCAN_EN = 1'b0; S = 3'd0;
    E_N = 3'b111; step();
    E_N = 3'b110; step();
    chk("dir_ch0", 64'(Y[W-1:0]), 64'(I[W-1:0]));
    E_N = 3'b111; step();

    // Direct mode, all selects including out-of-range 5..7.
    E_N = 3'b000;
    for (int s = 0; s < 8; s++) begin
      rand_data();
      S = SW'(s);
      step();
      if (s >= IN) chk("dir_oor_y", 64'(Y), 64'd0);
    end

    // Scan from 0 with wrap 4 -> 0.
    MODE = 1'b1; SCAN_EN = 1'b1;
    for (int k = 0; k < 7; k++) begin
      rand_data();
      step();
      chk("scan_seq", 64'(SEL_Q), 64'(k % IN));
    end

    // Load and advance in the same cycle: old count used, loaded value next.
    LOAD = 1'b1; S = 3'd4; step();
    chk("ld_old", 64'(SEL_Q), 64'd2);
    LOAD = 1'b0; step();
    chk("ld_new", 64'(SEL_Q), 64'd4);
    chk("ld_tc", 64'(TC), 64'd1);
    step();
    chk("ld_wrap", 64'(SEL_Q), 64'd0);

    // Out-of-range load clamps to 0.
    step(); step();
    LOAD = 1'b1; S = 3'd7; step();
    LOAD = 1'b0; step();
    chk("ld_clamp", 64'(SEL_Q), 64'd0);

    // Direct mode holds the count; scan resumes from it.
    MODE = 1'b0; S = 3'd3; step(); step(); step();
    MODE = 1'b1; step();

    // Parked on the last input: TC stays high, data still live.
    LOAD = 1'b1; S = 3'd4; SCAN_EN = 1'b0; step();
    LOAD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_data(); step();
      chk("park_tc", 64'(TC), 64'd1);
    end

    // Reset mid-scan restarts at input 0.
    SCAN_EN = 1'b1; LOAD = 1'b1; S = 3'd2; step();
    LOAD = 1'b0; RST = 1'b1; step();
    RST = 1'b0; step();
    chk("rst_restart", 64'(SEL_Q), 64'd0);
    step();

    // Random stimulus.
    for (int n = 0; n < 400; n++) begin
      rand_data();
      RST     = ($urandom_range(0, 29) == 0);
      LOAD    = ($urandom_range(0, 7) == 0);
      MODE    = 1'($urandom);
      SCAN_EN = ($urandom_range(0, 3) != 0);
      E_N     = CH'($urandom);
      S       = SW'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
